// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with internal pixel strobe divider
// All decoded outputs are registered from the next coordinates so sync, VDE and counters stay aligned.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIX_DIV  = 4,
   parameter int CNT_W    = 13
) (
   input  logic             CLK100M,
   input  logic             RST_N,
   input  logic             EN,
   output logic             PIX_CE,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             VDE,
   output logic [CNT_W-1:0] HCNT,
   output logic [CNT_W-1:0] VCNT,
   output logic             LINE_END,
   output logic             FRAME_START,
   output logic [15:0]      FRAME_CNT
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if (H_SYNC < 1 || V_SYNC < 1 || PIX_DIV < 1) begin : g_bad_params
      $error("vga_timing_gen: H_SYNC, V_SYNC and PIX_DIV must be at least 1");
   end
   if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end

   logic [DIV_W-1:0] r_div;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_vcnt;
   logic [15:0]      r_frame_cnt;
   logic             r_pix_ce;
   logic             r_line_end;
   logic             r_frame_start;
   logic             r_vde;
   logic             r_hs;
   logic             r_vs;

   logic             w_adv;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic [CNT_W-1:0] w_h_nxt;
   logic [CNT_W-1:0] w_v_nxt;
   logic [15:0]      w_fc_nxt;
   logic [DIV_W-1:0] w_div_nxt;

   always_comb begin
      w_adv     = EN && (r_div == DIV_LAST);
      w_h_wrap  = (r_hcnt == H_LAST);
      w_v_wrap  = (r_vcnt == V_LAST);
      w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;
      w_h_nxt   = w_h_wrap ? '0 : r_hcnt + CNT_ONE;
      w_v_nxt   = r_vcnt;
      w_fc_nxt  = r_frame_cnt;
      if (w_h_wrap) begin
         w_v_nxt = w_v_wrap ? '0 : r_vcnt + CNT_ONE;
         if (w_v_wrap) begin
            w_fc_nxt = r_frame_cnt + 16'd1;
         end
      end
   end

   // Reset parks the raster on the last pixel so the first advance lands on (0,0).
   always_ff @(posedge CLK100M or negedge RST_N) begin
      if (!RST_N) begin
         r_div         <= '0;
         r_hcnt        <= H_LAST;
         r_vcnt        <= V_LAST;
         r_frame_cnt   <= 16'hFFFF;
         r_pix_ce      <= 1'b0;
         r_line_end    <= 1'b0;
         r_frame_start <= 1'b0;
         r_vde         <= 1'b0;
         r_hs          <= ~HS_POL;
         r_vs          <= ~VS_POL;
      end else begin
         r_pix_ce      <= w_adv;
         r_line_end    <= w_adv && (w_h_nxt == H_LAST);
         r_frame_start <= w_adv && (w_h_nxt == '0) && (w_v_nxt == '0);
         if (EN) begin
            r_div <= w_div_nxt;
         end
         if (w_adv) begin
            r_hcnt      <= w_h_nxt;
            r_vcnt      <= w_v_nxt;
            r_frame_cnt <= w_fc_nxt;
            r_vde       <= (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
            r_hs        <= ((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END)) ? HS_POL : ~HS_POL;
            r_vs        <= ((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END)) ? VS_POL : ~VS_POL;
         end
      end
   end

   assign PIX_CE      = r_pix_ce;
   assign LINE_END    = r_line_end;
   assign FRAME_START = r_frame_start;
   assign HCNT        = r_hcnt;
   assign VCNT        = r_vcnt;
   assign FRAME_CNT   = r_frame_cnt;
   assign VDE         = r_vde;
   assign VGA_HS      = r_hs;
   assign VGA_VS      = r_vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default and small raster instances)
module tb_vga_timing_gen;

   typedef struct {
      logic [12:0] h;
      logic [12:0] v;
      logic        vde;
      logic        hs;
      logic        vs;
      logic        le;
      logic        fs;
      logic [15:0] fc;
      int          gap;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q_big[$];
   exp_t q_small[$];

   logic        b_rst_n, b_en, b_pix_ce, b_hs, b_vs, b_vde, b_le, b_fs;
   logic [12:0] b_hcnt, b_vcnt;
   logic [15:0] b_fcnt;
   logic        s_rst_n, s_en, s_pix_ce, s_hs, s_vs, s_vde, s_le, s_fs;
   logic [12:0] s_hcnt, s_vcnt;
   logic [15:0] s_fcnt;

   vga_timing_gen u_big (
      .CLK100M(clk), .RST_N(b_rst_n), .EN(b_en), .PIX_CE(b_pix_ce),
      .VGA_HS(b_hs), .VGA_VS(b_vs), .VDE(b_vde), .HCNT(b_hcnt), .VCNT(b_vcnt),
      .LINE_END(b_le), .FRAME_START(b_fs), .FRAME_CNT(b_fcnt)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1), .CNT_W(13)
   ) u_small (
      .CLK100M(clk), .RST_N(s_rst_n), .EN(s_en), .PIX_CE(s_pix_ce),
      .VGA_HS(s_hs), .VGA_VS(s_vs), .VDE(s_vde), .HCNT(s_hcnt), .VCNT(s_vcnt),
      .LINE_END(s_le), .FRAME_START(s_fs), .FRAME_CNT(s_fcnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Default 640x480 expectations: HS low at 656..751, VS low on lines 490..491.
   task automatic push_big(input int v, input int h, input logic [15:0] fc, input int gap);
      exp_t e;
      e.h   = 13'(h);
      e.v   = 13'(v);
      e.vde = (h < 640) && (v < 480);
      e.hs  = !((h >= 656) && (h < 752));
      e.vs  = !((v >= 490) && (v < 492));
      e.le  = (h == 799);
      e.fs  = (h == 0) && (v == 0);
      e.fc  = fc;
      e.gap = gap;
      q_big.push_back(e);
   endtask

   // Small raster 8x6: HS high at h 5..6, VS high on v 4, VDE for h<4 and v<3.
   task automatic push_small(input int v, input int h, input logic [15:0] fc, input int gap);
      exp_t e;
      e.h   = 13'(h);
      e.v   = 13'(v);
      e.vde = (h < 4) && (v < 3);
      e.hs  = (h == 5) || (h == 6);
      e.vs  = (v == 4);
      e.le  = (h == 7);
      e.fs  = (h == 0) && (v == 0);
      e.fc  = fc;
      e.gap = gap;
      q_small.push_back(e);
   endtask

   task automatic push_small_frames(input logic [15:0] fc0);
      for (int f = 0; f < 2; f++)
         for (int v = 0; v < 6; v++)
            for (int h = 0; h < 8; h++)
               push_small(v, h, 16'(fc0 + 16'(f)), (f == 0 && v == 0 && h == 0) ? 0 : 1);
      push_small(0, 0, 16'(fc0 + 16'd2), 1);
   endtask

   int b_last_ce = 0, b_le_t = 0, b_le_n = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!b_rst_n) begin
         b_le_n = 0;
      end else begin
         if (b_pix_ce) begin
            if (q_big.size() > 0) begin
               e = q_big.pop_front();
               check("b_hcnt", 32'(b_hcnt), 32'(e.h));
               check("b_vcnt", 32'(b_vcnt), 32'(e.v));
               check("b_vde", 32'(b_vde), 32'(e.vde));
               check("b_hs", 32'(b_hs), 32'(e.hs));
               check("b_vs", 32'(b_vs), 32'(e.vs));
               check("b_line_end", 32'(b_le), 32'(e.le));
               check("b_frame_start", 32'(b_fs), 32'(e.fs));
               check("b_frame_cnt", 32'(b_fcnt), 32'(e.fc));
               if (e.gap != 0) check("b_pix_gap", 32'(cyc - b_last_ce), 32'(e.gap));
            end
            b_last_ce = cyc;
         end else begin
            check("b_pulse_without_ce", 32'({b_le, b_fs}), 32'd0);
         end
         if (b_le) begin
            b_le_n++;
            if (b_le_n == 2) check("b_line_period", 32'(cyc - b_le_t), 32'd3200);
            b_le_t = cyc;
         end
      end
   end

   int s_last_ce = 0, s_fs_t = 0, s_fs_n = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!s_rst_n) begin
         s_fs_n = 0;
      end else begin
         if (s_pix_ce) begin
            if (q_small.size() > 0) begin
               e = q_small.pop_front();
               check("s_hcnt", 32'(s_hcnt), 32'(e.h));
               check("s_vcnt", 32'(s_vcnt), 32'(e.v));
               check("s_vde", 32'(s_vde), 32'(e.vde));
               check("s_hs", 32'(s_hs), 32'(e.hs));
               check("s_vs", 32'(s_vs), 32'(e.vs));
               check("s_line_end", 32'(s_le), 32'(e.le));
               check("s_frame_start", 32'(s_fs), 32'(e.fs));
               check("s_frame_cnt", 32'(s_fcnt), 32'(e.fc));
               if (e.gap != 0) check("s_pix_gap", 32'(cyc - s_last_ce), 32'(e.gap));
            end
            s_last_ce = cyc;
         end
         if (s_fs) begin
            s_fs_n++;
            if (s_fs_n == 2) check("s_frame_period", 32'(cyc - s_fs_t), 32'd48);
            s_fs_t = cyc;
         end
      end
   end

   task automatic check_big_reset(input string tag);
      check({tag, "_hcnt"}, 32'(b_hcnt), 32'd799);
      check({tag, "_vcnt"}, 32'(b_vcnt), 32'd524);
      check({tag, "_vde_hs_vs"}, 32'({b_vde, b_hs, b_vs}), 32'b011);
      check({tag, "_pulses"}, 32'({b_pix_ce, b_le, b_fs}), 32'd0);
      check({tag, "_fcnt"}, 32'(b_fcnt), 32'hFFFF);
   endtask

   task automatic check_small_reset(input string tag);
      check({tag, "_hcnt"}, 32'(s_hcnt), 32'd7);
      check({tag, "_vcnt"}, 32'(s_vcnt), 32'd5);
      check({tag, "_vde_hs_vs"}, 32'({s_vde, s_hs, s_vs}), 32'b000);
      check({tag, "_pulses"}, 32'({s_pix_ce, s_le, s_fs}), 32'd0);
      check({tag, "_fcnt"}, 32'(s_fcnt), 32'hFFFF);
   endtask

   task automatic drain_big(input int limit);
      for (int i = 0; i < limit && q_big.size() > 0; i++) @(negedge clk);
      check("b_queue_drained", 32'(q_big.size()), 32'd0);
   endtask

   task automatic drain_small(input int limit);
      for (int i = 0; i < limit && q_small.size() > 0; i++) @(negedge clk);
      check("s_queue_drained", 32'(q_small.size()), 32'd0);
   endtask

   initial begin
      int b_lat, s_lat, found;
      b_rst_n = 1'b0; s_rst_n = 1'b0; b_en = 1'b0; s_en = 1'b0;
      repeat (3) @(negedge clk);
      check_big_reset("b_reset");
      check_small_reset("s_reset");

      for (int v = 0; v < 2; v++)
         for (int h = 0; h < 800; h++)
            push_big(v, h, 16'd0, (v == 0 && h == 0) ? 0 : 4);
      for (int h = 0; h <= 100; h++) push_big(2, h, 16'd0, 4);
      push_small_frames(16'd0);

      b_en = 1'b1; s_en = 1'b1; b_rst_n = 1'b1; s_rst_n = 1'b1;
      b_lat = 0; s_lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (s_pix_ce && s_lat == 0) s_lat = n;
         if (b_pix_ce && b_lat == 0) b_lat = n;
      end
      check("s_first_latency", 32'(s_lat), 32'd1);
      check("b_first_latency", 32'(b_lat), 32'd4);
      drain_small(200);

      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         @(negedge clk);
         if (s_vcnt == 13'd2) found = 1;
      end
      check("s_reach_v2", 32'(found), 32'd1);
      #2 s_rst_n = 1'b0;
      #1 check_small_reset("s_async_reset");
      @(negedge clk) s_en = 1'b0;
      @(negedge clk) s_rst_n = 1'b1;
      @(negedge clk);
      check("s_hold_after_reset", 32'({s_hcnt, s_pix_ce}), 32'({13'd7, 1'b0}));
      force u_small.r_frame_cnt = 16'hFFFD;
      @(negedge clk);
      release u_small.r_frame_cnt;
      push_small_frames(16'hFFFE);
      s_en = 1'b1;
      drain_small(200);

      found = 0;
      for (int i = 0; i < 10000 && found == 0; i++) begin
         @(negedge clk);
         if (b_pix_ce && b_vcnt == 13'd2 && b_hcnt == 13'd100) found = 1;
      end
      check("b_reach_h100", 32'(found), 32'd1);
      b_en = 1'b0;
      push_big(2, 101, 16'd0, 14);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("b_frozen_coords", 32'({b_vcnt, b_hcnt}), 32'({13'd2, 13'd100}));
         check("b_frozen_levels", 32'({b_vde, b_hs, b_vs, b_fcnt}), 32'({3'b111, 16'd0}));
         check("b_frozen_pulses", 32'({b_pix_ce, b_le, b_fs}), 32'd0);
      end
      b_en = 1'b1;
      drain_big(50);

      @(negedge clk);
      #2 b_rst_n = 1'b0;
      #1 check_big_reset("b_async_reset");
      for (int h = 0; h <= 20; h++) push_big(0, h, 16'd0, (h == 0) ? 0 : 4);
      @(negedge clk) b_rst_n = 1'b1;
      b_lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (b_pix_ce && b_lat == 0) b_lat = n;
      end
      check("b_restart_latency", 32'(b_lat), 32'd4);
      drain_big(200);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
